// File: rtl/cia_ctrl_pkg.sv
// Shared types and constants for the CIA bus controller.
//   state_e : controller FSM states
//   src_e   : transaction source (auto-ICR, port 0, port 1)
//   RS_ICR  : register select of the CIA interrupt control register
package cia_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_CAPTURE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SRC_ICR = 2'd0,
    SRC_P0  = 2'd1,
    SRC_P1  = 2'd2
  } src_e;

  localparam logic [3:0] RS_ICR = 4'hD;

endpackage

// File: rtl/cia_phase_gen.sv
// Phase counter for the CIA bus timing.
// The counter runs 0..PHI2_DIV-1 and wraps. Phase PHI2_DIV-2 is the bus slot,
// phase PHI2_DIV-1 carries the phi2 strobe.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   phi2         : one-clk strobe in the last phase
//   slot_next    : high in the phase immediately before the bus slot, so the
//                  controller can register its bus outputs for the slot
module cia_phase_gen #(
  parameter int unsigned PHI2_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic phi2,
  output logic slot_next
);

  localparam int unsigned PW = (PHI2_DIV > 2) ? $clog2(PHI2_DIV) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(PHI2_DIV - 1);
  // With a divider of 2 the slot is phase 0, so the phase before it is phase 1.
  localparam logic [PW-1:0] PH_PRE  = (PHI2_DIV == 2) ? PW'(1) : PW'(PHI2_DIV - 3);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;

  always_comb begin
    phase_d = phase_q + PW'(1);
    if (phase_q == PH_LAST) begin
      phase_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phi2      = (phase_q == PH_LAST);
  assign slot_next = (phase_q == PH_PRE);

endmodule

// File: rtl/cia_bus_ctrl.sv
// Two-port arbiter and bus sequencer for a CIA-style peripheral, with an
// optional automatic ICR read on interrupt.
// Ports:
//   clk, reset_n             : clock, async active-low reset
//   reqN/addrN/weN/wdataN    : requester N level request and transaction
//   ackN                     : one-cycle completion pulse for port N
//   rdata                    : data of the last completed port read (held)
//   phi2                     : one-clk phi2 strobe
//   cia_cs_n/cia_rw/cia_rs/cia_db_in : bus to the CIA, valid in the slot
//   cia_db_out               : read data from the CIA
//   cia_irq_n                : CIA interrupt, active low
//   icr_value/icr_valid      : captured ICR byte and its strobe
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | arbitrate; latch winner's transaction on leaving
// ST_GRANT   | wait for the phase before the bus slot
// ST_ACCESS  | cs_n low for the single slot clock
// ST_CAPTURE | read data latched, ack / icr_valid pulse high
module cia_bus_ctrl
  import cia_ctrl_pkg::*;
#(
  parameter int unsigned PHI2_DIV = 4,
  parameter int unsigned AUTO_ICR = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] addr0,
  input  logic [3:0] addr1,
  input  logic       we0,
  input  logic       we1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       phi2,
  output logic       cia_cs_n,
  output logic       cia_rw,
  output logic [3:0] cia_rs,
  output logic [7:0] cia_db_in,
  input  logic [7:0] cia_db_out,
  input  logic       cia_irq_n,
  output logic [7:0] icr_value,
  output logic       icr_valid
);

  logic slot_next;

  cia_phase_gen #(
    .PHI2_DIV (PHI2_DIV)
  ) u_phase (
    .clk       (clk),
    .reset_n   (reset_n),
    .phi2      (phi2),
    .slot_next (slot_next)
  );

  state_e     state_q, state_d;
  src_e       src_q, src_d;
  logic [3:0] addr_q, addr_d;
  logic       we_q, we_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rr_q, rr_d;          // 1: port 1 wins a tie next time
  logic       holdoff_q, holdoff_d;
  logic       cs_n_q, cs_n_d;
  logic       rw_q, rw_d;
  logic [3:0] rs_q, rs_d;
  logic [7:0] db_in_q, db_in_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] icr_value_q, icr_value_d;
  logic       icr_valid_q, icr_valid_d;
  logic       icr_elig;

  assign icr_elig = (AUTO_ICR != 0) && !cia_irq_n && !holdoff_q;

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    rr_d        = rr_q;
    // The holdoff drops once the CIA has visibly released IRQ.
    holdoff_d   = cia_irq_n ? 1'b0 : holdoff_q;
    cs_n_d      = 1'b1;
    rw_d        = 1'b1;
    rs_d        = rs_q;
    db_in_d     = db_in_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata_d     = rdata_q;
    icr_value_d = icr_value_q;
    icr_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (icr_elig) begin
          src_d   = SRC_ICR;
          addr_d  = RS_ICR;
          we_d    = 1'b0;
          wdata_d = 8'h00;
          state_d = ST_GRANT;
        end else if (req0 && (!req1 || !rr_q)) begin
          src_d   = SRC_P0;
          addr_d  = addr0;
          we_d    = we0;
          wdata_d = wdata0;
          rr_d    = 1'b1;
          state_d = ST_GRANT;
        end else if (req1) begin
          src_d   = SRC_P1;
          addr_d  = addr1;
          we_d    = we1;
          wdata_d = wdata1;
          rr_d    = 1'b0;
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (slot_next) begin
          cs_n_d  = 1'b0;
          rw_d    = !we_q;
          rs_d    = addr_q;
          db_in_d = wdata_q;
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (src_q == SRC_ICR) begin
          icr_value_d = cia_db_out;
          icr_valid_d = 1'b1;
        end else begin
          if (!we_q) begin
            rdata_d = cia_db_out;
          end
          ack0_d = (src_q == SRC_P0);
          ack1_d = (src_q == SRC_P1);
        end
        // Any ICR read clears the CIA's interrupt, but IRQ only rises at the
        // following phi2; block a second auto read until then.
        if (!we_q && (addr_q == RS_ICR)) begin
          holdoff_d = 1'b1;
        end
        state_d = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      src_q       <= SRC_P0;
      addr_q      <= 4'h0;
      we_q        <= 1'b0;
      wdata_q     <= 8'h00;
      rr_q        <= 1'b0;
      holdoff_q   <= 1'b0;
      cs_n_q      <= 1'b1;
      rw_q        <= 1'b1;
      rs_q        <= 4'h0;
      db_in_q     <= 8'h00;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata_q     <= 8'h00;
      icr_value_q <= 8'h00;
      icr_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      rr_q        <= rr_d;
      holdoff_q   <= holdoff_d;
      cs_n_q      <= cs_n_d;
      rw_q        <= rw_d;
      rs_q        <= rs_d;
      db_in_q     <= db_in_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata_q     <= rdata_d;
      icr_value_q <= icr_value_d;
      icr_valid_q <= icr_valid_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign cia_cs_n  = cs_n_q;
  assign cia_rw    = rw_q;
  assign cia_rs    = rs_q;
  assign cia_db_in = db_in_q;
  assign icr_value = icr_value_q;
  assign icr_valid = icr_valid_q;

endmodule

// File: tb/tb_cia_bus_ctrl.sv
// Bench for cia_bus_ctrl: a transaction-schedule model predicts every output
// on every cycle; directed scenarios add literal expectations.
module tb_cia_bus_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0, req1;
  logic [3:0] addr0, addr1;
  logic       we0, we1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata;
  logic       phi2;
  logic       cia_cs_n, cia_rw;
  logic [3:0] cia_rs;
  logic [7:0] cia_db_in, cia_db_out;
  logic       cia_irq_n;
  logic [7:0] icr_value;
  logic       icr_valid;

  logic [7:0] cia_mem [16];
  assign cia_db_out = cia_mem[cia_rs];

  always #5 clk = ~clk;

  cia_bus_ctrl #(.PHI2_DIV(DIV), .AUTO_ICR(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .we0(we0), .we1(we1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .phi2(phi2),
    .cia_cs_n(cia_cs_n), .cia_rw(cia_rw), .cia_rs(cia_rs),
    .cia_db_in(cia_db_in), .cia_db_out(cia_db_out), .cia_irq_n(cia_irq_n),
    .icr_value(icr_value), .icr_valid(icr_valid)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model: the transaction in flight and its scheduled slot cycle
  bit         m_busy;
  int         m_acc;
  int         m_src;            // 0 icr, 1 port0, 2 port1
  logic [3:0] m_addr;
  bit         m_we;
  logic [7:0] m_wdata;
  bit         m_pref1;
  bit         m_hold;
  logic [3:0] m_rs;
  logic [7:0] m_db, m_rdata, m_icr;

  // logs of observed bus activity
  int         cs_cyc[$];
  logic [3:0] cs_rs[$];
  bit         cs_rw[$];
  logic [7:0] cs_db[$];
  int         ack_order[$];
  int         ack0_cnt, ack1_cnt, icrv_cnt;

  // CIA interrupt release model
  int rel_at, rel_done, rel_mode;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timeout at cycle %0d", nm, cyc);
  endtask

  task automatic model_reset();
    m_busy = 0; m_acc = -10; m_src = 1; m_addr = 0; m_we = 0; m_wdata = 0;
    m_pref1 = 0; m_hold = 0; m_rs = 0; m_db = 0; m_rdata = 0; m_icr = 0;
  endtask

  task automatic clear_logs();
    cs_cyc.delete(); cs_rs.delete(); cs_rw.delete(); cs_db.delete();
    ack_order.delete();
    ack0_cnt = 0; ack1_cnt = 0; icrv_cnt = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_phi2"},  int'(phi2), 0);
    chk({tag, "_cs_n"},  int'(cia_cs_n), 1);
    chk({tag, "_rw"},    int'(cia_rw), 1);
    chk({tag, "_rs"},    int'(cia_rs), 0);
    chk({tag, "_db_in"}, int'(cia_db_in), 0);
    chk({tag, "_ack0"},  int'(ack0), 0);
    chk({tag, "_ack1"},  int'(ack1), 0);
    chk({tag, "_rdata"}, int'(rdata), 0);
    chk({tag, "_icrv"},  int'(icr_value), 0);
    chk({tag, "_icrs"},  int'(icr_valid), 0);
  endtask

  task automatic compare_cycle();
    bit in_slot, in_cap;
    in_slot = m_busy && (cyc == m_acc);
    in_cap  = m_busy && (cyc == m_acc + 1);
    chk("phi2",      int'(phi2), int'((cyc % DIV) == DIV - 1));
    chk("cs_n",      int'(cia_cs_n), int'(!in_slot));
    chk("rw",        int'(cia_rw), in_slot ? int'(!m_we) : 1);
    chk("rs",        int'(cia_rs), in_slot ? int'(m_addr) : int'(m_rs));
    chk("db_in",     int'(cia_db_in), in_slot ? int'(m_wdata) : int'(m_db));
    chk("ack0",      int'(ack0), int'(in_cap && m_src == 1));
    chk("ack1",      int'(ack1), int'(in_cap && m_src == 2));
    chk("icr_valid", int'(icr_valid), int'(in_cap && m_src == 0));
    chk("rdata",     int'(rdata), int'(m_rdata));
    chk("icr_value", int'(icr_value), int'(m_icr));
    if (!cia_cs_n) begin
      cs_cyc.push_back(cyc); cs_rs.push_back(cia_rs);
      cs_rw.push_back(cia_rw); cs_db.push_back(cia_db_in);
    end
    if (ack0) begin ack0_cnt++; ack_order.push_back(0); end
    if (ack1) begin ack1_cnt++; ack_order.push_back(1); end
    if (icr_valid) icrv_cnt++;
  endtask

  // Inputs for this cycle are already driven; they are what the DUT samples
  // at the coming posedge.
  task automatic model_update();
    bit set_hold;
    bit granted;
    set_hold = 0;
    granted  = 0;
    if (m_busy) begin
      if (cyc == m_acc) begin
        m_rs = m_addr;
        m_db = m_wdata;
        if (!m_we) begin
          if (m_src == 0) m_icr = cia_mem[m_addr];
          else            m_rdata = cia_mem[m_addr];
          if (m_addr == 4'hD) set_hold = 1;
        end
      end
      if (cyc == m_acc + 1) m_busy = 0;
    end else begin
      if (!cia_irq_n && !m_hold) begin
        m_src = 0; m_addr = 4'hD; m_we = 0; m_wdata = 8'h00; granted = 1;
      end else if (req0 && (!req1 || !m_pref1)) begin
        m_src = 1; m_addr = addr0; m_we = we0; m_wdata = wdata0;
        m_pref1 = 1; granted = 1;
      end else if (req1) begin
        m_src = 2; m_addr = addr1; m_we = we1; m_wdata = wdata1;
        m_pref1 = 0; granted = 1;
      end
      if (granted) begin
        m_busy = 1;
        m_acc  = cyc + 2;
        while ((m_acc % DIV) != DIV - 2) m_acc++;
      end
    end
    if (set_hold)       m_hold = 1;
    else if (cia_irq_n) m_hold = 0;
  endtask

  task automatic irq_release();
    if (!cia_cs_n && cia_rw && cia_rs == 4'hD) begin
      bit slow;
      slow = (rel_mode == 1) || (rel_mode == 2 && ($urandom % 2) == 1);
      rel_at = cyc + 1 + (slow ? DIV : 0);
    end
    if (rel_at >= 0 && cyc == rel_at) begin
      cia_irq_n = 1'b1;
      rel_at    = -1;
      rel_done  = cyc;
    end
  endtask

  task automatic rand_port(input int p);
    logic [3:0] a;
    a = (($urandom % 8) == 0) ? 4'hD : 4'($urandom);
    if (p == 0) begin addr0 = a; we0 = 1'($urandom); wdata0 = 8'($urandom); end
    else        begin addr1 = a; we1 = 1'($urandom); wdata1 = 8'($urandom); end
  endtask

  task automatic drive_random();
    if (ack0) begin
      if (($urandom % 4) != 0) req0 = 1'b0; else rand_port(0);
    end else if (!req0) begin
      if (($urandom % 5) == 0) begin req0 = 1'b1; rand_port(0); end
    end else begin
      if (($urandom % 40) == 0) req0 = 1'b0;
      else if (($urandom % 10) == 0) rand_port(0);
    end
    if (ack1) begin
      if (($urandom % 4) != 0) req1 = 1'b0; else rand_port(1);
    end else if (!req1) begin
      if (($urandom % 5) == 0) begin req1 = 1'b1; rand_port(1); end
    end else begin
      if (($urandom % 40) == 0) req1 = 1'b0;
      else if (($urandom % 10) == 0) rand_port(1);
    end
    if (cia_irq_n && rel_at < 0 && cyc > rel_done && ($urandom % 30) == 0) begin
      cia_irq_n   = 1'b0;
      cia_mem[13] = 8'($urandom);
    end
  endtask

  task automatic step(input bit rnd);
    compare_cycle();
    irq_release();
    if (rnd) drive_random();
    model_update();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_ack(input int p, input int budget, output int n);
    bit done;
    done = 0;
    n = 0;
    while (!done && n < budget) begin
      step(0);
      n++;
      if ((p == 0 && ack0) || (p == 1 && ack1)) done = 1;
    end
    if (!done) timeout(p == 0 ? "wait_ack0" : "wait_ack1");
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, icr_reads;
    bit ok;
    req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; we0 = 0; we1 = 0;
    wdata0 = 0; wdata1 = 0; cia_irq_n = 1'b1;
    rel_at = -1; rel_done = -100; rel_mode = 0;
    for (int i = 0; i < 16; i++) cia_mem[i] = 8'($urandom);
    cia_mem[0] = 8'h5A; cia_mem[3] = 8'hC3; cia_mem[13] = 8'h81;

    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    cyc = 0;
    model_reset();
    clear_logs();

    // port 0 write, uncontended
    req0 = 1; addr0 = 4'h2; we0 = 1; wdata0 = 8'hFF;
    wait_ack(0, 20, lat);
    chk("p0w_latency_le6", int'(lat <= 6), 1);
    chk("p0w_latency", lat, 3);
    chk("model_acc_first", m_acc, 2);
    idle(3);
    chk("p0w_cs_count", cs_cyc.size(), 1);
    if (cs_cyc.size() == 1) begin
      chk("p0w_cs_phase", cs_cyc[0] % DIV, 2);
      chk("p0w_rw", int'(cs_rw[0]), 0);
      chk("p0w_rs", int'(cs_rs[0]), 2);
      chk("p0w_db", int'(cs_db[0]), 8'hFF);
    end
    chk("p0w_ack0_count", ack0_cnt, 1);
    chk("p0w_no_ack1", ack1_cnt, 0);

    // port 1 read
    clear_logs();
    req1 = 1; addr1 = 4'h0; we1 = 0; wdata1 = 8'h33;
    wait_ack(1, 20, lat);
    chk("p1r_rdata_at_ack", int'(rdata), 8'h5A);
    idle(3);
    chk("p1r_cs_count", cs_cyc.size(), 1);
    if (cs_cyc.size() == 1) begin
      chk("p1r_rw", int'(cs_rw[0]), 1);
      chk("p1r_rs", int'(cs_rs[0]), 0);
    end
    chk("p1r_rdata_held", int'(rdata), 8'h5A);
    chk("p1r_no_ack0", ack0_cnt, 0);

    // simultaneous requests, 4 transactions per port
    clear_logs();
    req0 = 1; rand_port(0); req1 = 1; rand_port(1);
    begin
      int n0, n1, guard;
      n0 = 0; n1 = 0; guard = 0;
      while ((n0 < 4 || n1 < 4) && guard < 300) begin
        step(0);
        guard++;
        if (ack0) begin n0++; if (n0 < 4) rand_port(0); else req0 = 0; end
        if (ack1) begin n1++; if (n1 < 4) rand_port(1); else req1 = 0; end
      end
      if (guard >= 300) timeout("rr_done");
    end
    idle(10);
    chk("rr_ack0_count", ack0_cnt, 4);
    chk("rr_ack1_count", ack1_cnt, 4);
    chk("rr_cs_count", cs_cyc.size(), 8);
    for (int i = 0; i < ack_order.size(); i++) chk("rr_order", ack_order[i], i % 2);
    ok = 1;
    for (int i = 1; i < cs_cyc.size(); i++) if (cs_cyc[i] - cs_cyc[i-1] < DIV) ok = 0;
    chk("rr_one_cs_per_slot", int'(ok), 1);

    // IRQ while port 0 is pending; CIA releases at the next phi2
    clear_logs();
    rel_mode = 0;
    req0 = 1; addr0 = 4'h5; we0 = 0; wdata0 = 8'h00;
    step(0);
    cia_irq_n = 1'b0;
    wait_ack(0, 20, lat);
    idle(20);
    chk("icr_cs_count", cs_cyc.size(), 2);
    if (cs_cyc.size() == 2) begin
      chk("icr_rs", int'(cs_rs[1]), 4'hD);
      chk("icr_rw", int'(cs_rw[1]), 1);
      chk("icr_next_slot", cs_cyc[1] - cs_cyc[0], DIV);
    end
    chk("icr_valid_count", icrv_cnt, 1);
    chk("icr_value", int'(icr_value), 8'h81);
    chk("icr_irq_released", int'(cia_irq_n), 1);

    // IRQ release lags a full phi2 period: the holdoff must still block
    clear_logs();
    rel_mode = 1;
    cia_mem[13] = 8'h42;
    cia_irq_n = 1'b0;
    idle(40);
    icr_reads = 0;
    for (int i = 0; i < cs_rs.size(); i++) if (cs_rs[i] == 4'hD) icr_reads++;
    chk("holdoff_icr_reads", icr_reads, 1);
    chk("holdoff_icrv_count", icrv_cnt, 1);
    chk("holdoff_icr_value", int'(icr_value), 8'h42);

    // reset during ACCESS
    req0 = 1; addr0 = 4'h7; we0 = 1; wdata0 = 8'h99;
    n = 0;
    while (cia_cs_n && n < 20) begin step(0); n++; end
    if (cia_cs_n) timeout("reach_access");
    #1 reset_n = 1'b0;
    #1 check_reset_vals("midrst");
    req0 = 0;
    @(negedge clk);
    chk("midrst_no_ack0", int'(ack0), 0);
    chk("midrst_cs_n_held", int'(cia_cs_n), 1);
    reset_n = 1'b1;
    cyc = 0;
    model_reset();
    clear_logs();
    idle(6);
    chk("midrst_no_cs", cs_cyc.size(), 0);
    chk("midrst_no_ack", ack0_cnt + ack1_cnt, 0);
    req0 = 1; addr0 = 4'h3; we0 = 0;
    wait_ack(0, 20, lat);
    chk("midrst_next_latency", int'(lat <= DIV + 2), 1);
    chk("midrst_next_rdata", int'(rdata), 8'hC3);

    // randomized traffic
    rel_mode = 2;
    for (int i = 0; i < 3000; i++) step(1);
    req0 = 0; req1 = 0;
    idle(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
